keccak_round_sequencer: RTL and testbench

//  Top-level scheduler for the permutation step engines (theta, rho, pi, chi, iota/addRc).
//  On start, runs NUM_ROUNDS rounds. Each round starts the five step engines in fixed order 0..4.

---
 rtl/keccak_round_sequencer_if.sv | 34 +++
 rtl/keccak_round_sequencer.sv | 162 ++++++++++++++++
 tb/tb_keccak_round_sequencer.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_round_sequencer_if.sv
// Purpose: handshake/bus bundle between the Keccak round sequencer and its
//          host and step engines (theta, rho, pi, chi, iota).
// Signals:
//   start       host -> seq   begin a permutation (sampled only while idle)
//   abort       host -> seq   synchronous abort, returns the sequencer to idle
//   step_ready  eng  -> seq   per-engine ready, bit i = engine i finished
//   step_start  seq  -> eng   one-hot, single-cycle start pulse
//   turn        seq  -> eng   current round index (round-constant select)
//   busy        seq  -> host  high whenever the sequencer is not idle
//   done        seq  -> host  single-cycle completion pulse
//   error       seq  -> host  sticky watchdog flag
// Modports: master = sequencer side, slave = host/engine side.
interface keccak_round_sequencer_if #(
  parameter int unsigned TURN_W = 5
);
  logic              start;
  logic              abort;
  logic [4:0]        step_ready;
  logic [4:0]        step_start;
  logic [TURN_W-1:0] turn;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    input  start, abort, step_ready,
    output step_start, turn, busy, done, error
  );

  modport slave (
    output start, abort, step_ready,
    input  step_start, turn, busy, done, error
  );
endinterface

// File: rtl/keccak_round_sequencer.sv
// Purpose: schedules the five Keccak step engines for NUM_ROUNDS rounds.
//          Each step: one-cycle start pulse (ISSUE), one cycle in which ready
//          is ignored (GAP), then wait for that engine's ready (WAIT).
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous reset, active-low
//   seq_if  keccak_round_sequencer_if.master (start/abort/step_ready in,
//           step_start/turn/busy/done/error out, all registered)
// Configuration: define ROUND_TIMEOUT_EN to enable the per-step watchdog
//   (TIMEOUT_CYCLES); otherwise error is tied low and WAIT waits forever.
module keccak_round_sequencer #(
  parameter int unsigned NUM_ROUNDS     = 24,
  parameter int unsigned TURN_W         = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  keccak_round_sequencer_if.master seq_if
);
  localparam int unsigned NUM_STEPS = 5;
  localparam int unsigned STEP_W    = 3;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [TURN_W-1:0] LAST_TURN = TURN_W'(NUM_ROUNDS - 1);

  // Elaboration-time parameter sanity check.
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > (1 << TURN_W) || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("keccak_round_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_GAP   = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [TURN_W-1:0]   turn_q, turn_d;
  logic [NUM_STEPS-1:0] step_start_q;
  logic                busy_q;
  logic                done_q;

`ifdef ROUND_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    turn_d  = turn_q;
`ifdef ROUND_TIMEOUT_EN
    cnt_d   = cnt_q;
    error_d = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (seq_if.start) begin
          state_d = S_ISSUE;
          step_d  = '0;
          turn_d  = '0;
`ifdef ROUND_TIMEOUT_EN
          error_d = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        state_d = S_GAP;
`ifdef ROUND_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_GAP: begin
        state_d = S_WAIT;
`ifdef ROUND_TIMEOUT_EN
        cnt_d   = cnt_q + CNT_W'(1);
`endif
      end
      S_WAIT: begin
`ifdef ROUND_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (seq_if.step_ready[step_q]) begin
          if (step_q < LAST_STEP) begin
            state_d = S_ISSUE;
            step_d  = step_q + STEP_W'(1);
          end else if (turn_q < LAST_TURN) begin
            state_d = S_ISSUE;
            step_d  = '0;
            turn_d  = turn_q + TURN_W'(1);
          end else begin
            state_d = S_DONE;
          end
        end
`ifdef ROUND_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // This WAIT cycle is the TIMEOUT_CYCLES-th counted cycle.
          state_d = S_IDLE;
          error_d = 1'b1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a start seen in IDLE.
    if (seq_if.abort) begin
      state_d = S_IDLE;
      step_d  = step_q;
      turn_d  = turn_q;
`ifdef ROUND_TIMEOUT_EN
      error_d = error_q;
`endif
    end
  end

  // State and registered outputs; step_start/busy are decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      turn_q       <= '0;
      step_start_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      turn_q       <= turn_d;
      step_start_q <= (state_d == S_ISSUE) ? (NUM_STEPS'(1) << step_d) : '0;
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_q == S_DONE) && !seq_if.abort;
    end
  end

`ifdef ROUND_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end
  assign seq_if.error = error_q;
`else
  assign seq_if.error = 1'b0;
`endif

  assign seq_if.step_start = step_start_q;
  assign seq_if.turn       = turn_q;
  assign seq_if.busy       = busy_q;
  assign seq_if.done       = done_q;

endmodule

// File: tb/tb_keccak_round_sequencer.sv
// Purpose: self-checking bench for keccak_round_sequencer. An engine model
//          drives step_ready (optionally stalling one step); a monitor logs
//          every step_start pulse and done pulse with its cycle number, and
//          each test compares the log against an expected-event queue.
module tb_keccak_round_sequencer;
  localparam int unsigned NUM_ROUNDS     = 24;
  localparam int unsigned TURN_W         = 5;
  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam int          NUM_EV         = NUM_ROUNDS * 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  keccak_round_sequencer_if #(.TURN_W(TURN_W)) seq_if ();

  keccak_round_sequencer #(
    .NUM_ROUNDS    (NUM_ROUNDS),
    .TURN_W        (TURN_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .rst   (rst_n),
    .seq_if(seq_if)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [4:0]        ss;
    logic [TURN_W-1:0] turn;
    int unsigned       cyc;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         obs_q[$];
  int unsigned done_cyc_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Monitor: log outputs on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (seq_if.step_start != 5'b0) obs_q.push_back('{seq_if.step_start, seq_if.turn, cyc});
      if (seq_if.done) done_cyc_q.push_back(cyc);
    end
  end

  // Engine model: ready = ready_base, except an optional stall of one step.
  logic [4:0]        ready_base = 5'h1f;
  bit                stall_en   = 1'b0;
  logic [TURN_W-1:0] stall_turn = '0;
  int                stall_step = 0;
  int                stall_k    = 1;
  int                stall_left = 0;
  logic [4:0]        stall_mask = 5'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_left = 0;
      stall_mask = 5'b0;
    end else if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) stall_mask = 5'b0;
    end else if (stall_en && seq_if.step_start[stall_step] && seq_if.turn == stall_turn) begin
      // Low from ISSUE through WAIT cycle k-1, high on WAIT cycle k.
      stall_mask = 5'b00001 << stall_step;
      stall_left = stall_k + 1;
    end
    seq_if.step_ready = ready_base & ~stall_mask;
  end

  // Expected step_start events: 3 cycles per step, plus extra after a stalled step.
  task automatic push_expected(input int unsigned t0, input int n_ev,
                               input int stall_idx, input int unsigned extra);
    exp_q.delete();
    for (int i = 0; i < n_ev; i++) begin
      ev_t e;
      e.ss   = 5'b00001 << (i % 5);
      e.turn = TURN_W'(i / 5);
      e.cyc  = t0 + 3 * i + ((stall_idx >= 0 && i > stall_idx) ? extra : 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_perm(output int unsigned t0);
    @(negedge clk);
    seq_if.start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    seq_if.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok, output int unsigned idle_cyc);
    ok = 1'b0;
    idle_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!seq_if.busy) begin
        ok = 1'b1;
        idle_cyc = cyc;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    seq_if.start = 1'b0;
    seq_if.abort = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({seq_if.step_start, seq_if.turn, seq_if.busy, seq_if.done, seq_if.error} !== '0) begin
      n_err++;
      $display("FAIL reset_vals: got ss=%b turn=%0d busy=%b done=%b err=%b, want all 0",
               seq_if.step_start, seq_if.turn, seq_if.busy, seq_if.done, seq_if.error);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({seq_if.step_start, seq_if.busy, seq_if.done} !== 7'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got ss=%b busy=%b done=%b, want 0", seq_if.step_start,
               seq_if.busy, seq_if.done);
    end
  endtask

  task automatic test_full_run();
    int unsigned t0, idle_cyc;
    bit ok;
    int obase = obs_q.size();
    int dbase = done_cyc_q.size();
    start_perm(t0);
    push_expected(t0, NUM_EV, -1, 0);
    wait_idle(600, ok, idle_cyc);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL full_timeout: busy never fell, want fall"); end
    n_vec++;
    if (obs_q.size() - obase != exp_q.size()) begin
      n_err++;
      $display("FAIL full_evcount: got %0d want %0d", obs_q.size() - obase, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && obase + i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[obase + i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL full_ev%0d: got ss=%b turn=%0d cyc=%0d want ss=%b turn=%0d cyc=%0d", i,
                 obs_q[obase+i].ss, obs_q[obase+i].turn, obs_q[obase+i].cyc - t0,
                 exp_q[i].ss, exp_q[i].turn, exp_q[i].cyc - t0);
      end
    end
    n_vec++;
    if (done_cyc_q.size() - dbase != 1) begin
      n_err++;
      $display("FAIL full_donecount: got %0d want 1", done_cyc_q.size() - dbase);
    end else begin
      n_vec++;
      if (done_cyc_q[dbase] - t0 != 361) begin
        n_err++;
        $display("FAIL full_latency: got %0d want 361", done_cyc_q[dbase] - t0);
      end
    end
    n_vec++;
    if (idle_cyc - t0 != 361) begin
      n_err++;
      $display("FAIL full_busyfall: got %0d want 361", idle_cyc - t0);
    end
    n_vec++;
    if (seq_if.turn !== TURN_W'(NUM_ROUNDS - 1)) begin
      n_err++;
      $display("FAIL full_turnhold: got %0d want %0d", seq_if.turn, NUM_ROUNDS - 1);
    end
  endtask

  task automatic test_stall();
    int unsigned t0, idle_cyc;
    bit ok;
    int obase = obs_q.size();
    int dbase = done_cyc_q.size();
    stall_turn = TURN_W'(7);
    stall_step = 2;
    stall_k    = 5;
    stall_en   = 1'b1;
    start_perm(t0);
    push_expected(t0, NUM_EV, 37, 4);
    while (cyc < t0 + 115) @(negedge clk);
    n_vec++;
    if (seq_if.turn !== TURN_W'(7) || seq_if.step_start !== 5'b0 || seq_if.busy !== 1'b1) begin
      n_err++;
      $display("FAIL stall_hold: got turn=%0d ss=%b busy=%b want turn=7 ss=0 busy=1",
               seq_if.turn, seq_if.step_start, seq_if.busy);
    end
    wait_idle(600, ok, idle_cyc);
    stall_en = 1'b0;
    n_vec++;
    if (obs_q.size() - obase != exp_q.size()) begin
      n_err++;
      $display("FAIL stall_evcount: got %0d want %0d", obs_q.size() - obase, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && obase + i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[obase + i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL stall_ev%0d: got ss=%b turn=%0d cyc=%0d want ss=%b turn=%0d cyc=%0d", i,
                 obs_q[obase+i].ss, obs_q[obase+i].turn, obs_q[obase+i].cyc - t0,
                 exp_q[i].ss, exp_q[i].turn, exp_q[i].cyc - t0);
      end
    end
    n_vec++;
    if (done_cyc_q.size() - dbase != 1 || !ok) begin
      n_err++;
      $display("FAIL stall_donecount: got %0d want 1", done_cyc_q.size() - dbase);
    end else begin
      n_vec++;
      if (done_cyc_q[dbase] - t0 != 365) begin
        n_err++;
        $display("FAIL stall_latency: got %0d want 365", done_cyc_q[dbase] - t0);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int unsigned t0, idle_cyc;
    bit ok;
    int obase = obs_q.size();
    int dbase = done_cyc_q.size();
    start_perm(t0);
    push_expected(t0, NUM_EV, -1, 0);
    while (cyc < t0 + 100) @(negedge clk);
    seq_if.start = 1'b1;
    @(negedge clk);
    seq_if.start = 1'b0;
    wait_idle(600, ok, idle_cyc);
    repeat (5) @(negedge clk);
    n_vec++;
    if (obs_q.size() - obase != exp_q.size()) begin
      n_err++;
      $display("FAIL rebusy_evcount: got %0d want %0d", obs_q.size() - obase, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && obase + i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[obase + i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rebusy_ev%0d: got ss=%b turn=%0d cyc=%0d want ss=%b turn=%0d cyc=%0d", i,
                 obs_q[obase+i].ss, obs_q[obase+i].turn, obs_q[obase+i].cyc - t0,
                 exp_q[i].ss, exp_q[i].turn, exp_q[i].cyc - t0);
      end
    end
    n_vec++;
    if (done_cyc_q.size() - dbase != 1 || !ok) begin
      n_err++;
      $display("FAIL rebusy_donecount: got %0d want 1", done_cyc_q.size() - dbase);
    end
  endtask

  task automatic test_abort();
    int unsigned t0, t1, idle_cyc;
    bit ok, found;
    int obase = obs_q.size();
    int dbase = done_cyc_q.size();
    start_perm(t0);
    push_expected(t0, 54, -1, 0);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (seq_if.step_start === 5'b01000 && seq_if.turn === TURN_W'(10)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL abort_find: round10 step3 not seen, want seen"); end
    seq_if.abort = 1'b1;
    @(negedge clk);
    seq_if.abort = 1'b0;
    n_vec++;
    if (seq_if.busy !== 1'b0 || seq_if.turn !== TURN_W'(10) || seq_if.step_start !== 5'b0) begin
      n_err++;
      $display("FAIL abort_idle: got busy=%b turn=%0d ss=%b want busy=0 turn=10 ss=0",
               seq_if.busy, seq_if.turn, seq_if.step_start);
    end
    repeat (20) @(negedge clk);
    n_vec++;
    if (done_cyc_q.size() != dbase) begin
      n_err++;
      $display("FAIL abort_nodone: got %0d done pulses want 0", done_cyc_q.size() - dbase);
    end
    n_vec++;
    if (obs_q.size() - obase != exp_q.size()) begin
      n_err++;
      $display("FAIL abort_evcount: got %0d want %0d", obs_q.size() - obase, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && obase + i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[obase + i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL abort_ev%0d: got ss=%b turn=%0d cyc=%0d want ss=%b turn=%0d cyc=%0d", i,
                 obs_q[obase+i].ss, obs_q[obase+i].turn, obs_q[obase+i].cyc - t0,
                 exp_q[i].ss, exp_q[i].turn, exp_q[i].cyc - t0);
      end
    end
    // start and abort together in IDLE: abort wins.
    obase = obs_q.size();
    seq_if.start = 1'b1;
    seq_if.abort = 1'b1;
    @(negedge clk);
    seq_if.start = 1'b0;
    seq_if.abort = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if (seq_if.busy !== 1'b0 || obs_q.size() != obase) begin
      n_err++;
      $display("FAIL start_abort_idle: got busy=%b events=%0d want busy=0 events=0",
               seq_if.busy, obs_q.size() - obase);
    end
    // Fresh start after abort runs from turn 0.
    obase = obs_q.size();
    dbase = done_cyc_q.size();
    start_perm(t1);
    push_expected(t1, NUM_EV, -1, 0);
    wait_idle(600, ok, idle_cyc);
    n_vec++;
    if (obs_q.size() - obase != exp_q.size()) begin
      n_err++;
      $display("FAIL rerun_evcount: got %0d want %0d", obs_q.size() - obase, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && obase + i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[obase + i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rerun_ev%0d: got ss=%b turn=%0d cyc=%0d want ss=%b turn=%0d cyc=%0d", i,
                 obs_q[obase+i].ss, obs_q[obase+i].turn, obs_q[obase+i].cyc - t1,
                 exp_q[i].ss, exp_q[i].turn, exp_q[i].cyc - t1);
      end
    end
    n_vec++;
    if (done_cyc_q.size() - dbase != 1 || !ok) begin
      n_err++;
      $display("FAIL rerun_donecount: got %0d want 1", done_cyc_q.size() - dbase);
    end
  endtask

  task automatic test_async_reset();
    int unsigned t0;
    stall_turn = TURN_W'(2);
    stall_step = 1;
    stall_k    = 50;
    stall_en   = 1'b1;
    start_perm(t0);
    while (cyc < t0 + 40) @(negedge clk);
    n_vec++;
    if (seq_if.busy !== 1'b1 || seq_if.turn !== TURN_W'(2)) begin
      n_err++;
      $display("FAIL arst_pre: got busy=%b turn=%0d want busy=1 turn=2", seq_if.busy, seq_if.turn);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({seq_if.step_start, seq_if.turn, seq_if.busy, seq_if.done, seq_if.error} !== '0) begin
      n_err++;
      $display("FAIL arst_immediate: got ss=%b turn=%0d busy=%b done=%b err=%b want all 0",
               seq_if.step_start, seq_if.turn, seq_if.busy, seq_if.done, seq_if.error);
    end
    stall_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (seq_if.busy !== 1'b0 || seq_if.step_start !== 5'b0) begin
      n_err++;
      $display("FAIL arst_release: got busy=%b ss=%b want 0", seq_if.busy, seq_if.step_start);
    end
  endtask

`ifdef ROUND_TIMEOUT_EN
  task automatic test_timeout();
    int unsigned t0, t1, err_cyc;
    bit found;
    int dbase = done_cyc_q.size();
    ready_base = 5'h0f;
    start_perm(t0);
    found = 1'b0;
    err_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (seq_if.error === 1'b1) begin
        found = 1'b1;
        err_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!found || err_cyc - t0 != 29) begin
      n_err++;
      $display("FAIL timeout_err: got found=%b at %0d want found=1 at 29", found, err_cyc - t0);
    end
    n_vec++;
    if (seq_if.busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_idle: got busy=%b want 0", seq_if.busy);
    end
    repeat (5) @(negedge clk);
    n_vec++;
    if (done_cyc_q.size() != dbase || seq_if.error !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_sticky: got done=%0d err=%b want done=0 err=1",
               done_cyc_q.size() - dbase, seq_if.error);
    end
    start_perm(t1);
    n_vec++;
    if (seq_if.error !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_clear: got err=%b want 0", seq_if.error);
    end
    seq_if.abort = 1'b1;
    @(negedge clk);
    seq_if.abort = 1'b0;
    ready_base = 5'h1f;
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_run();
    test_stall();
    test_start_while_busy();
    test_abort();
    test_async_reset();
`ifdef ROUND_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
